jtcontra_snd_cmd: RTL and testbench
===================================

Name: jtcontra_snd_cmd

Overview:
Sound-CPU end of the main→sound command channel. Captures the 8-bit command that the main CPU leaves on its sound latch when the main CPU pulses its sound IRQ strobe. Drives the sound CPU's active-low IRQ until that CPU acknowledges the interrupt and reads the command. Sits between the main CPU block and the sound-side jtframe_sys6809 instance, all on one clock.

Parameters:
FIFO_AW, 2, log2 of command FIFO depth; used only when JTCONTRA_SNDCMD_FIFO_EN is defined
OVR_STICKY, 1, 1: overrun flag holds until ovr_clr; 0: overrun flag clears on the next successful read

Ports:
clk  in  1  system clock, 24 MHz
rstn  in  1  asynchronous active-low reset
main_irq  in  1  sound IRQ strobe from main CPU; one or more clk cycles high per command
main_latch  in  8  main CPU sound latch; stable whenever main_irq rises
snd_cen  in  1  sound CPU clock enable (cpu_cen of sound sys6809)
latch_cs  in  1  sound CPU address decode for the command register
snd_rnw  in  1  sound CPU read/not-write
irq_ack  in  1  IRQ acknowledge from sound sys6809
ovr_clr  in  1  clears overrun flag, qualified by snd_cen
snd_irqn  out  1  IRQ to sound CPU, active low
cmd_dout  out  8  command presented to sound CPU data mux
overrun  out  1  a command was lost or overwritten
pending  out  FIFO_AW+1  number of unread commands (0/1 without the FIFO)

Behaviour:
- Reset, asynchronous, rstn low: snd_irqn=1, cmd_dout=8'h00, overrun=0, pending=0, state=IDLE, edge register=0.
- Capture: main_irq_l registered every clk; capture fires when main_irq & ~main_irq_l. Capture ignores snd_cen. main_latch is sampled in the same cycle. A held-high main_irq counts as one command only.
- Read event: latch_cs & snd_rnw & snd_cen. The event consumes the head entry. cmd_dout shows the head combinationally-stable (registered head), so read data has zero added latency.
- States:
  - IDLE: snd_irqn=1, pending=0.
  - PEND: snd_irqn=0, unread command exists, IRQ not yet acked.
  - SERV: snd_irqn=1, command acked but not yet read.
- Transitions:
  - IDLE→PEND on capture; snd_irqn low on the next clk edge.
  - PEND→SERV on irq_ack & snd_cen.
  - PEND→IDLE on a read event with no further entries (polling without IRQ).
  - SERV→IDLE on a read event when pending becomes 0.
  - SERV→PEND, or PEND stays, on a read event leaving pending≠0 (the next command re-raises IRQ).
  - Capture in PEND or SERV: handled per storage mode; state→PEND.
- Simultaneous capture and read in the same cycle: the read consumes the old head and the new command becomes or joins the queue. Never lost in FIFO mode. Without the FIFO, the new value loads and pending stays 1, state PEND.
- Simultaneous irq_ack and read in PEND: treat as the read (PEND→IDLE or stays PEND per pending).
- Without the FIFO, capture while pending=1 overwrites cmd_dout and sets overrun.
- pending saturates at 2^FIFO_AW; it never wraps.
- Overrun flag:
  - Set on any lost or overwritten command.
  - Cleared by ovr_clr & snd_cen.
  - If OVR_STICKY=0, also cleared by a read event.
  - A set and a clear in the same cycle: set wins.
- Writes with latch_cs & ~snd_rnw are ignored.

Optional Feature:
JTCONTRA_SNDCMD_FIFO_EN
- Defined: 2^FIFO_AW-entry circular FIFO with pointers that wrap modulo depth.
  - Capture when full: command dropped, overrun set, FIFO contents unchanged.
  - Capture and read together when full: accepted, no overrun.
  - cmd_dout = head entry.
- Undefined: single holding register, overwrite semantics as above. FIFO_AW is ignored and pending is 0 or 1.

Decomposition:
- Shared package jtcontra_snd_pkg: state enum (IDLE, PEND, SERV), CMD_W=8, reset value of cmd_dout.
- One natural sub-module, jtcontra_snd_fifo (circular buffer: push, pop, full, empty, count), instantiated only under the macro.
- The top keeps edge detection, the state machine and the overrun logic.

Test Plan:
- Reset, then main_latch=8'h5A with a 1-cycle main_irq → next clk snd_irqn=0, cmd_dout=8'h5A, pending=1; irq_ack → snd_irqn=1; read → pending=0, state IDLE.
- main_irq held high 10 cycles with main_latch=8'h11 → exactly one capture, pending=1.
- Without FIFO: commands 8'h01 then 8'h02 with no read → cmd_dout=8'h02, overrun=1; ovr_clr → overrun=0.
- With FIFO, FIFO_AW=2: push 8'hA0..A4 (5 commands) → pending=4, overrun=1; four reads return A0, A1, A2, A3 and IRQ re-asserts after each read until empty.
- Capture coincident with a read of 8'h33, new value 8'h44 → read returns 8'h33, next cmd_dout=8'h44, snd_irqn=0, no overrun.
- rstn pulsed low mid-PEND, asynchronous, between clk edges → snd_irqn=1 and pending=0 immediately; a capture after release works normally.

Source files
------------

// File: rtl/jtcontra_snd_pkg.sv
// Shared types and constants for the main-to-sound command channel.
package jtcontra_snd_pkg;

  localparam int CMD_W = 8;
  localparam logic [CMD_W-1:0] CMD_RST = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_t;

endpackage

// File: rtl/jtcontra_snd_fifo.sv
// Circular command buffer used when JTCONTRA_SNDCMD_FIFO_EN is defined.
// The caller only asserts push when space exists or a pop happens in the same cycle.
module jtcontra_snd_fifo
  import jtcontra_snd_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;

  // When full, a push paired with a pop lands in the slot being vacated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= CMD_RST;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (pop) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_cnt == DEPTH[AW:0]);
  assign empty = (r_cnt == '0);
  assign count = r_cnt;

endmodule

// File: rtl/jtcontra_snd_cmd.sv
// Sound-CPU side of the main-to-sound command latch with IRQ handshake.
// Define JTCONTRA_SNDCMD_FIFO_EN to queue commands instead of overwriting them.
module jtcontra_snd_cmd
  import jtcontra_snd_pkg::*;
#(
  parameter int FIFO_AW    = 2,
  parameter bit OVR_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             main_irq,
  input  logic [CMD_W-1:0] main_latch,
  input  logic             snd_cen,
  input  logic             latch_cs,
  input  logic             snd_rnw,
  input  logic             irq_ack,
  input  logic             ovr_clr,
  output logic             snd_irqn,
  output logic [CMD_W-1:0] cmd_dout,
  output logic             overrun,
  output logic [FIFO_AW:0] pending
);

  state_t           r_st, w_st_nxt;
  logic             r_irq_l;
  logic             r_ovr;
  logic             w_cap, w_rd, w_ack, w_pop, w_lost;
  logic [FIFO_AW:0] w_cnt, w_cnt_nxt;

  assign w_cap = main_irq & ~r_irq_l;
  assign w_rd  = latch_cs & snd_rnw & snd_cen;
  assign w_ack = irq_ack & snd_cen;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_irq_l <= 1'b0;
    else       r_irq_l <= main_irq;
  end

`ifdef JTCONTRA_SNDCMD_FIFO_EN
  logic w_push, w_full, w_empty;

  assign w_pop     = w_rd & ~w_empty;
  assign w_push    = w_cap & (~w_full | w_pop);
  assign w_lost    = w_cap & ~w_push;
  assign w_cnt_nxt = w_cnt + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

  jtcontra_snd_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .din   (main_latch),
    .dout  (cmd_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );
`else
  logic             r_pend;
  logic [CMD_W-1:0] r_cmd;

  // A fresh capture always wins the holding register, even during a read.
  assign w_pop     = w_rd & r_pend;
  assign w_lost    = w_cap & r_pend & ~w_pop;
  assign w_cnt     = {{FIFO_AW{1'b0}}, r_pend};
  assign w_cnt_nxt = {{FIFO_AW{1'b0}}, w_cap | (r_pend & ~w_pop)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= 1'b0;
      r_cmd  <= CMD_RST;
    end else begin
      r_pend <= w_cap | (r_pend & ~w_pop);
      if (w_cap) r_cmd <= main_latch;
    end
  end

  assign cmd_dout = r_cmd;
`endif

  // Set has priority over both clear sources.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_ovr <= 1'b0;
    else if (w_lost)
      r_ovr <= 1'b1;
    else if ((ovr_clr & snd_cen) | (~OVR_STICKY & w_pop))
      r_ovr <= 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_st <= IDLE;
    else       r_st <= w_st_nxt;
  end

  // A read outranks a same-cycle acknowledge.
  always_comb begin
    w_st_nxt = r_st;
    snd_irqn = 1'b1;
    if (w_cap)
      w_st_nxt = PEND;
    else if (w_pop)
      w_st_nxt = (w_cnt_nxt == '0) ? IDLE : PEND;
    else if (r_st == PEND && w_ack)
      w_st_nxt = SERV;
    if (r_st == PEND) snd_irqn = 1'b0;
  end

  assign overrun = r_ovr;
  assign pending = w_cnt;

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Directed, table-driven bench for jtcontra_snd_cmd (either storage mode).
module tb_jtcontra_snd_cmd;

  localparam int AW = 2;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          main_irq, snd_cen, latch_cs, snd_rnw, irq_ack, ovr_clr;
  logic [7:0]    main_latch;
  logic          snd_irqn, overrun;
  logic [7:0]    cmd_dout;
  logic [PW-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  jtcontra_snd_cmd #(.FIFO_AW(AW), .OVR_STICKY(1'b1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .main_irq   (main_irq),
    .main_latch (main_latch),
    .snd_cen    (snd_cen),
    .latch_cs   (latch_cs),
    .snd_rnw    (snd_rnw),
    .irq_ack    (irq_ack),
    .ovr_clr    (ovr_clr),
    .snd_irqn   (snd_irqn),
    .cmd_dout   (cmd_dout),
    .overrun    (overrun),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          irq;
    logic [7:0]    lat;
    logic          cen, cs, rnw, ack, clr;
    logic          e_irqn;
    logic [7:0]    e_dout;
    logic          e_ovr;
    logic [PW-1:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic irq, input logic [7:0] lat,
                              input logic cen, cs, rnw, ack, clr,
                              input logic e_irqn, input logic [7:0] e_dout,
                              input logic e_ovr, input int e_pend);
    vec_t v;
    v.irq = irq; v.lat = lat; v.cen = cen; v.cs = cs; v.rnw = rnw;
    v.ack = ack; v.clr = clr; v.e_irqn = e_irqn; v.e_dout = e_dout;
    v.e_ovr = e_ovr; v.e_pend = PW'(e_pend);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic irq, input logic [7:0] lat, input logic cen,
                      input logic cs, input logic rnw, input logic ack, input logic clr);
    main_irq = irq; main_latch = lat; snd_cen = cen;
    latch_cs = cs; snd_rnw = rnw; irq_ack = ack; ovr_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 8'h00, 1, 0, 0, 0, 0);
  endtask

  task automatic capture(input logic [7:0] v);
    step(1, v, 1, 0, 0, 0, 0);
    idle();
  endtask

  task automatic rd();
    step(0, 8'h00, 1, 1, 1, 0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    main_irq = 0; main_latch = 8'h00; snd_cen = 1; latch_cs = 0;
    snd_rnw = 0; irq_ack = 0; ovr_clr = 0;
    #12;
    chk("rst_irqn", snd_irqn, 1'b1);
    chk("rst_dout", cmd_dout, 8'h00);
    chk("rst_ovr",  overrun, 1'b0);
    chk("rst_pend", pending, 0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    //            irq lat    cen cs rnw ack clr  irqn dout   ovr pend
    tbl.push_back(mk(1, 8'h5A, 1, 0, 0, 0, 0,   0, 8'h5A, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0,   1, 8'h5A, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h5A, 0, 0));
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 0, 0,   0, 8'h01, 0, 1));
    tbl.push_back(mk(1, 8'h09, 1, 0, 0, 0, 0,   0, 8'h01, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0,   0, 8'h01, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h01, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h08, 1, 0, 0, 0, 0,   0, 8'h08, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0,   0, 8'h08, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 0,   1, 8'h08, 0, 0));
    tbl.push_back(mk(1, 8'h0C, 1, 0, 0, 0, 0,   0, 8'h0C, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0,   1, 8'h0C, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1,   1, 8'h0C, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0,   1, 8'h0C, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].irq, tbl[i].lat, tbl[i].cen, tbl[i].cs, tbl[i].rnw, tbl[i].ack, tbl[i].clr);
      chk($sformatf("vec%0d_irqn", i), snd_irqn, tbl[i].e_irqn);
      chk($sformatf("vec%0d_ovr",  i), overrun,  tbl[i].e_ovr);
      chk($sformatf("vec%0d_pend", i), pending,  tbl[i].e_pend);
      if (tbl[i].e_pend != 0)
        chk($sformatf("vec%0d_dout", i), cmd_dout, tbl[i].e_dout);
    end

    // Held-high strobe is a single command.
    for (int i = 0; i < 10; i++) step(1, 8'h11, 1, 0, 0, 0, 0);
    idle();
    chk("hold_pend", pending, 1);
    chk("hold_dout", cmd_dout, 8'h11);
    rd();
    chk("hold_rd_pend", pending, 0);

`ifdef JTCONTRA_SNDCMD_FIFO_EN
    for (int i = 0; i < 5; i++) capture(8'hA0 + 8'(i));
    chk("fifo_full_pend", pending, 4);
    chk("fifo_full_ovr", overrun, 1'b1);
    step(0, 8'h00, 1, 0, 0, 0, 1);
    chk("fifo_clr_ovr", overrun, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fifo_head%0d", i), cmd_dout, 8'hA0 + 8'(i));
      step(0, 8'h00, 1, 0, 0, 1, 0);
      chk($sformatf("fifo_ack%0d_irqn", i), snd_irqn, 1'b1);
      rd();
      chk($sformatf("fifo_rd%0d_irqn", i), snd_irqn, (i < 3) ? 1'b0 : 1'b1);
      chk($sformatf("fifo_rd%0d_pend", i), pending, 3 - i);
    end
    for (int i = 0; i < 4; i++) capture(8'hC0 + 8'(i));
    step(1, 8'hC4, 1, 1, 1, 0, 0);
    chk("fifo_fullrd_pend", pending, 4);
    chk("fifo_fullrd_ovr", overrun, 1'b0);
    chk("fifo_fullrd_head", cmd_dout, 8'hC1);
    idle();
    for (int i = 0; i < 4; i++) rd();
    chk("fifo_drain_pend", pending, 0);
`else
    capture(8'h01);
    capture(8'h02);
    chk("ovw_dout", cmd_dout, 8'h02);
    chk("ovw_ovr", overrun, 1'b1);
    chk("ovw_pend", pending, 1);
    rd();
    chk("ovw_sticky", overrun, 1'b1);
    step(0, 8'h00, 1, 0, 0, 0, 1);
    chk("ovw_clr", overrun, 1'b0);
    capture(8'h06);
    step(1, 8'h07, 1, 0, 0, 0, 1);
    chk("ovw_setwins", overrun, 1'b1);
    chk("ovw_setwins_dout", cmd_dout, 8'h07);
    step(0, 8'h00, 1, 0, 0, 0, 1);
    chk("ovw_clr2", overrun, 1'b0);
    rd();
`endif

    // Capture coincident with a read of the current head.
    capture(8'h33);
    main_irq = 1; main_latch = 8'h44; snd_cen = 1; latch_cs = 1; snd_rnw = 1;
    #1;
    chk("coin_rd_data", cmd_dout, 8'h33);
    @(posedge clk); #1;
    chk("coin_dout", cmd_dout, 8'h44);
    chk("coin_irqn", snd_irqn, 1'b0);
    chk("coin_ovr", overrun, 1'b0);
    chk("coin_pend", pending, 1);
    idle();

    // Asynchronous reset between edges while PEND.
    #3 rstn = 1'b0;
    #1;
    chk("arst_irqn", snd_irqn, 1'b1);
    chk("arst_pend", pending, 0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    capture(8'h77);
    chk("arst_cap_irqn", snd_irqn, 1'b0);
    chk("arst_cap_dout", cmd_dout, 8'h77);
    chk("arst_cap_pend", pending, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
